// File: rtl/ad7928_emu.sv
// AD7928 slave-side emulator: oversamples the master's CS/SCLK/DIN, shifts conversion frames out on DOUT
// and decodes the 12-bit control word. Define AD7928_EMU_TESTPAT_EN to replace ch_data with per-channel ramps.
module ad7928_emu #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int INIT_CH     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adc_cs,
    input  logic               adc_sclk,
    input  logic               adc_din,
    output logic               adc_dout,
    input  logic [NCH*12-1:0]  ch_data,
    output logic [11:0]        ctrl_reg,
    output logic               ctrl_vld,
    output logic               frame_err,
    output logic [2:0]         cur_ch
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Synchronizers reset to the idle pin levels so leaving reset never looks like an edge.
    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
    logic                   cs_q, sclk_q;
    logic                   cs_s, sclk_s, din_s;
    logic                   cs_fall, cs_rise, sclk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            din_sync  <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], adc_din};
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    state_t      state, state_d;
    logic [3:0]  bcnt, bcnt_d;
    logic [15:0] shadow, shadow_d;
    logic [15:0] rx, rx_d;
    logic        dout_d;
    logic [11:0] ctrl_d;
    logic [2:0]  cur_d;
    logic        vld_d, err_d;
    logic        frame_done;
    logic [11:0] sample, payload;
    logic        sample_hit;

`ifdef AD7928_EMU_TESTPAT_EN
    logic [11:0] ramp [NCH];
    logic        unused_testpat;

    always_comb begin
        sample         = '0;
        sample_hit     = 1'b0;
        unused_testpat = ^ch_data;
        for (int k = 0; k < NCH; k++) begin
            unused_testpat = unused_testpat ^ (^ramp[k][11:9]);
            if (int'(cur_ch) == k) begin
                sample     = {cur_ch, ramp[k][8:0]};
                sample_hit = 1'b1;
            end
        end
    end

    // NOTE: the ramp array is a handful of registers, not a RAM, so it can and must be cleared by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) ramp[k] <= '0;
        end else if (frame_done) begin
            for (int k = 0; k < NCH; k++) begin
                if (int'(shadow[14:12]) == k) ramp[k] <= ramp[k] + 12'd1;
            end
        end
    end
`else
    always_comb begin
        sample     = '0;
        sample_hit = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(cur_ch) == k) begin
                sample     = ch_data[k*12 +: 12];
                sample_hit = 1'b1;
            end
        end
    end
`endif

    // CODING=0 selects two's complement, which for an offset-binary sample is just the MSB inverted.
    assign payload = !sample_hit ? 12'h000 :
                     ctrl_reg[0] ? sample : {~sample[11], sample[10:0]};

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state;
        bcnt_d     = bcnt;
        shadow_d   = shadow;
        rx_d       = rx;
        dout_d     = adc_dout;
        ctrl_d     = ctrl_reg;
        cur_d      = cur_ch;
        vld_d      = 1'b0;
        err_d      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    shadow_d = {1'b0, cur_ch, payload};
                    dout_d   = shadow_d[15];
                    rx_d     = '0;
                    bcnt_d   = 4'd0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // The 16th falling edge wins over a coincident CS rise: the frame is complete.
                if (sclk_fall && bcnt == 4'd15) begin
                    rx_d[0]    = din_s;
                    dout_d     = 1'b0;
                    bcnt_d     = 4'd0;
                    frame_done = 1'b1;
                    if (rx[15]) begin
                        ctrl_d = rx[15:4];
                        cur_d  = rx[12:10];
                        vld_d  = 1'b1;
                    end
                    state_d = cs_rise ? IDLE : DONE;
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    rx_d    = '0;
                    dout_d  = 1'b0;
                    bcnt_d  = 4'd0;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    rx_d[4'd15 - bcnt] = din_s;
                    dout_d             = shadow[4'd14 - bcnt];
                    bcnt_d             = bcnt + 4'd1;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    dout_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcnt      <= '0;
            shadow    <= '0;
            rx        <= '0;
            adc_dout  <= 1'b0;
            ctrl_reg  <= 12'h000;
            cur_ch    <= 3'(INIT_CH);
            ctrl_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            bcnt      <= bcnt_d;
            shadow    <= shadow_d;
            rx        <= rx_d;
            adc_dout  <= dout_d;
            ctrl_reg  <= ctrl_d;
            cur_ch    <= cur_d;
            ctrl_vld  <= vld_d;
            frame_err <= err_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rx[3:0], shadow[15]};

endmodule

// File: tb/tb_ad7928_emu.sv
// Directed bench for ad7928_emu: a behavioural master drives frames from a vector table,
// then hand-written sequences cover the channel sweep, CS/SCLK coincidence and reset mid-frame.
module tb_ad7928_emu;

    localparam int NCH = 8;
    localparam int H   = 8;  // clk cycles per SCLK half period

    logic              clk;
    logic              rst_n;
    logic              adc_cs;
    logic              adc_sclk;
    logic              adc_din;
    logic              adc_dout;
    logic [NCH*12-1:0] ch_data;
    logic [11:0]       ctrl_reg;
    logic              ctrl_vld;
    logic              frame_err;
    logic [2:0]        cur_ch;

    ad7928_emu #(.NCH(NCH), .SYNC_STAGES(2), .INIT_CH(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_cs    (adc_cs),
        .adc_sclk  (adc_sclk),
        .adc_din   (adc_din),
        .adc_dout  (adc_dout),
        .ch_data   (ch_data),
        .ctrl_reg  (ctrl_reg),
        .ctrl_vld  (ctrl_vld),
        .frame_err (frame_err),
        .cur_ch    (cur_ch)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;

    always @(posedge clk) begin
        if (ctrl_vld === 1'b1)  vld_cnt <= vld_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Background k*0x111 on every channel, optionally one channel overridden.
    task automatic set_ch(input int och, input logic [11:0] osamp);
        for (int k = 0; k < NCH; k++) ch_data[k*12 +: 12] = 12'(k * 'h111);
        if (och >= 0) ch_data[och*12 +: 12] = osamp;
    endtask

    // Master: din set while SCLK high, dout sampled just before each SCLK fall.
    task automatic do_frame(input logic [15:0] word, input int nfalls, input bit simul,
                            output logic [15:0] got);
        got = '0;
        @(negedge clk);
        adc_cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nfalls; i++) begin
            adc_din = word[15-i];
            repeat (H) @(negedge clk);
            got[15-i] = adc_dout;
            adc_sclk  = 1'b0;
            if (simul && i == nfalls - 1) adc_cs = 1'b1;
            repeat (H) @(negedge clk);
            adc_sclk = 1'b1;
        end
        repeat (H) @(negedge clk);
        adc_cs = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] din;
        int          nfalls;
        int          och;
        logic [11:0] osamp;
        logic [15:0] exp_dout;
        int          exp_vld;
        int          exp_err;
        logic [11:0] exp_ctrl;
        logic [2:0]  exp_ch;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [15:0] got;
        logic [15:0] exp_w;
        int          v0, e0, prev;

        // ctrl_reg resets to 0, so the first frame uses CODING=0 (sample MSB inverted).
        vecs[0] = '{16'h8F10, 16, 0, 12'hABC, 16'h02BC, 1, 0, 12'h8F1, 3'd3};
        vecs[1] = '{16'h7F10, 16, 3, 12'h123, 16'h3123, 0, 0, 12'h8F1, 3'd3};
        vecs[2] = '{16'h9700, 16, 3, 12'h456, 16'h3456, 1, 0, 12'h970, 3'd5};
        vecs[3] = '{16'h9700, 16, 5, 12'h800, 16'h5000, 1, 0, 12'h970, 3'd5};
        vecs[4] = '{16'h9700, 16, 5, 12'h7FF, 16'h5FFF, 1, 0, 12'h970, 3'd5};
        // Abort after 9 falls: only the top 9 frame bits (0x5B21) reach the master.
        vecs[5] = '{16'hFF10,  9, 5, 12'h321, 16'h5B00, 0, 1, 12'h970, 3'd5};
        vecs[6] = '{16'h8F10, 16, 5, 12'hABC, 16'h52BC, 1, 0, 12'h8F1, 3'd3};
        vecs[7] = '{16'h9F10, 16, 3, 12'hFFF, 16'h3FFF, 1, 0, 12'h9F1, 3'd7};
        vecs[8] = '{16'h0000, 16, 7, 12'h000, 16'h7000, 0, 0, 12'h9F1, 3'd7};

        rst_n    = 1'b0;
        adc_cs   = 1'b1;
        adc_sclk = 1'b1;
        adc_din  = 1'b0;
        set_ch(-1, 12'h000);
        repeat (4) @(negedge clk);
        check("reset adc_dout", 32'(adc_dout), 32'd0);
        check("reset ctrl_reg", 32'(ctrl_reg), 32'h000);
        check("reset ctrl_vld", 32'(ctrl_vld), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset cur_ch", 32'(cur_ch), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            set_ch(vecs[i].och, vecs[i].osamp);
            v0 = vld_cnt;
            e0 = err_cnt;
            do_frame(vecs[i].din, vecs[i].nfalls, 1'b0, got);
            check($sformatf("vec%0d dout", i), 32'(got), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d ctrl_vld pulses", i), 32'(vld_cnt - v0), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d frame_err pulses", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d ctrl_reg", i), 32'(ctrl_reg), 32'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d cur_ch", i), 32'(cur_ch), 32'(vecs[i].exp_ch));
            check($sformatf("vec%0d idle adc_dout", i), 32'(adc_dout), 32'd0);
        end

        // Sequencer sweep: each frame returns the channel addressed by the previous one.
        set_ch(-1, 12'h000);
        for (int k = 0; k < NCH; k++) begin
            prev  = (k + NCH - 1) % NCH;
            exp_w = {1'b0, 3'(prev), 12'(prev * 'h111)};
            do_frame(16'h8310 | 16'(k << 10), 16, 1'b0, got);
            check($sformatf("sweep ch%0d dout", k), 32'(got), 32'(exp_w));
        end

        // CS rise coincident with the 16th SCLK fall completes the frame.
        v0 = vld_cnt;
        e0 = err_cnt;
        do_frame(16'h8B10, 16, 1'b1, got);
        check("simul dout", 32'(got), 32'h7777);
        check("simul frame_err pulses", 32'(err_cnt - e0), 32'd0);
        check("simul ctrl_vld pulses", 32'(vld_cnt - v0), 32'd1);
        check("simul ctrl_reg", 32'(ctrl_reg), 32'h8B1);
        check("simul cur_ch", 32'(cur_ch), 32'd2);

        // Reset mid-frame after 5 SCLK falls.
        @(negedge clk);
        adc_cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            adc_din = 1'b1;
            repeat (H) @(negedge clk);
            adc_sclk = 1'b0;
            repeat (H) @(negedge clk);
            adc_sclk = 1'b1;
        end
        repeat (H) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midreset ctrl_reg", 32'(ctrl_reg), 32'h000);
        check("midreset cur_ch", 32'(cur_ch), 32'd0);
        check("midreset adc_dout", 32'(adc_dout), 32'd0);
        adc_cs   = 1'b1;
        adc_sclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        v0 = vld_cnt;
        e0 = err_cnt;
        do_frame(16'h0000, 16, 1'b0, got);
        check("post-reset dout", 32'(got), 32'h0800);
        check("post-reset frame_err pulses", 32'(err_cnt - e0), 32'd0);
        check("post-reset ctrl_vld pulses", 32'(vld_cnt - v0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
